// File: rtl/output_writer.sv
// rtl/output_writer.sv - reassembles padded NWRITE payload packets into one user data stream
// Padding beats are dropped, first/last/keep regenerated; a small FIFO absorbs sink back-pressure.
module output_writer #(
   parameter int DATA_WIDTH        = 64,
   parameter int DATA_LENGTH_WIDTH = 16,
   parameter int RAM_ADDR_WIDTH    = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic [DATA_WIDTH-1:0]        input_tdata,
   input  logic                         input_tvalid,
   input  logic                         input_tfirst,
   input  logic                         input_tlast,
   input  logic [DATA_LENGTH_WIDTH-1:0] input_data_len,
   output logic                         input_tready,
   output logic [DATA_WIDTH-1:0]        data_out,
   output logic                         data_valid_out,
   output logic                         data_first_out,
   output logic                         data_last_out,
   output logic [7:0]                   data_keep_out,
   output logic [DATA_LENGTH_WIDTH-1:0] data_len_out,
   input  logic                         data_ready_in,
   output logic                         done_o,
   output logic                         error_o
);

   localparam int DLW   = DATA_LENGTH_WIDTH;
   localparam int BW    = DLW - 3;
   localparam int PW    = DLW - 7;
   localparam int AW    = RAM_ADDR_WIDTH;
   localparam int DEPTH = 1 << AW;
   localparam int EW    = DATA_WIDTH + 8 + 2 + DLW;

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_RECV    = 2'd1;
   localparam logic [1:0] S_DISCARD = 2'd2;

   logic [1:0]     state;
   logic           run;
   logic [BW-1:0]  beats_total;
   logic [BW-1:0]  beat_cnt;
   logic [PW-1:0]  pkts_total;
   logic [PW-1:0]  pkt_cnt;
   logic [7:0]     last_keep;
   logic [DLW-1:0] len_q;
   logic           after_last;

   logic [EW-1:0]  mem [DEPTH];
   logic [AW:0]    wr_ptr;
   logic [AW:0]    rd_ptr;
   logic           full;
   logic           empty;
   logic           rd_en;
   logic [EW-1:0]  rd_entry;

   logic           accept;
   logic           idle;
   logic           start;
   logic           in_xfer;
   logic           wr_beat;
   logic [BW-1:0]  new_beats;
   logic [PW-1:0]  new_pkts;
   logic [7:0]     new_keep;
   logic [BW-1:0]  cur_beats_total;
   logic [PW-1:0]  cur_pkts_total;
   logic [7:0]     cur_keep;
   logic [DLW-1:0] cur_len;
   logic [BW-1:0]  beat_next;
   logic [PW-1:0]  pkt_next;
   logic           hit_beats;
   logic           final_pkt;
   logic           wr_last;
   logic [7:0]     wr_keep;

   assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign empty = (wr_ptr == rd_ptr);

   // run holds ready low until the first clock after reset is released
   assign input_tready = run & ((state == S_DISCARD) | ~full);
   assign accept       = input_tvalid & input_tready;
   assign idle         = (state == S_IDLE);
   assign start        = idle & input_tfirst;
   assign in_xfer      = start | ~idle;
   assign wr_beat      = accept & (start | (state == S_RECV));

   assign new_beats = input_data_len[DLW-1:3] + BW'(1);
   assign new_pkts  = {1'b0, input_data_len[DLW-1:8]} + PW'(1);
   assign new_keep  = 8'hFF << (3'd7 - input_data_len[2:0]);

   // in IDLE the freshly computed totals apply to the beat being accepted
   assign cur_beats_total = idle ? new_beats : beats_total;
   assign cur_pkts_total  = idle ? new_pkts : pkts_total;
   assign cur_keep        = idle ? new_keep : last_keep;
   assign cur_len         = idle ? input_data_len : len_q;
   assign beat_next       = (idle ? '0 : beat_cnt) + BW'(1);
   assign pkt_next        = (idle ? '0 : pkt_cnt) + PW'(1);

   assign hit_beats = (beat_next == cur_beats_total);
   assign final_pkt = input_tlast & (pkt_next == cur_pkts_total);
   assign wr_last   = hit_beats | final_pkt;
   assign wr_keep   = hit_beats ? cur_keep : 8'hFF;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         run         <= 1'b0;
         beats_total <= '0;
         beat_cnt    <= '0;
         pkts_total  <= '0;
         pkt_cnt     <= '0;
         last_keep   <= '0;
         len_q       <= '0;
         after_last  <= 1'b0;
         done_o      <= 1'b0;
         error_o     <= 1'b0;
      end else begin
         run     <= 1'b1;
         done_o  <= accept & in_xfer & final_pkt;
         error_o <= accept & ((idle & ~input_tfirst)
                            | (~idle & input_tfirst & ~after_last)
                            | (wr_beat & final_pkt & ~hit_beats));
         if (accept) begin
            after_last <= input_tlast;
         end
         if (accept & in_xfer) begin
            if (start) begin
               beats_total <= new_beats;
               pkts_total  <= new_pkts;
               last_keep   <= new_keep;
               len_q       <= input_data_len;
            end
            if (wr_beat) begin
               beat_cnt <= beat_next;
            end
            if (input_tlast) begin
               pkt_cnt <= pkt_next;
            end else if (start) begin
               pkt_cnt <= '0;
            end
            if (final_pkt) begin
               state <= S_IDLE;
            end else if (wr_beat & hit_beats) begin
               state <= S_DISCARD;
            end else if (start) begin
               state <= S_RECV;
            end
         end
      end
   end

   // length travels with each entry so back-to-back transfers never show a stale length
   always_ff @(posedge clk) begin
      if (wr_beat) begin
         mem[wr_ptr[AW-1:0]] <= {input_tdata, wr_keep, start, wr_last, cur_len};
      end
   end

   assign rd_en    = (data_ready_in | ~data_valid_out) & ~empty;
   assign rd_entry = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         wr_ptr         <= '0;
         rd_ptr         <= '0;
         data_out       <= '0;
         data_valid_out <= 1'b0;
         data_first_out <= 1'b0;
         data_last_out  <= 1'b0;
         data_keep_out  <= '0;
         data_len_out   <= '0;
      end else begin
         if (wr_beat) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (rd_en) begin
            rd_ptr         <= rd_ptr + 1'b1;
            data_valid_out <= 1'b1;
            data_out       <= rd_entry[EW-1 -: DATA_WIDTH];
            data_keep_out  <= rd_entry[DLW+9 -: 8];
            data_first_out <= rd_entry[DLW+1];
            data_last_out  <= rd_entry[DLW];
            if (rd_entry[DLW+1]) begin
               data_len_out <= rd_entry[DLW-1:0];
            end
         end else if (data_ready_in) begin
            data_valid_out <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_output_writer.sv
// tb/tb_output_writer.sv - randomized bench for output_writer against a packet-level reference model
module tb_output_writer;

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] input_tdata;
   logic        input_tvalid;
   logic        input_tfirst;
   logic        input_tlast;
   logic [15:0] input_data_len;
   logic        input_tready;
   logic [63:0] data_out;
   logic        data_valid_out;
   logic        data_first_out;
   logic        data_last_out;
   logic [7:0]  data_keep_out;
   logic [15:0] data_len_out;
   logic        data_ready_in;
   logic        done_o;
   logic        error_o;

   always #5 clk = ~clk;

   output_writer #(.DATA_WIDTH(64), .DATA_LENGTH_WIDTH(16), .RAM_ADDR_WIDTH(4)) dut (
      .clk(clk), .reset(reset),
      .input_tdata(input_tdata), .input_tvalid(input_tvalid), .input_tfirst(input_tfirst),
      .input_tlast(input_tlast), .input_data_len(input_data_len), .input_tready(input_tready),
      .data_out(data_out), .data_valid_out(data_valid_out), .data_first_out(data_first_out),
      .data_last_out(data_last_out), .data_keep_out(data_keep_out), .data_len_out(data_len_out),
      .data_ready_in(data_ready_in), .done_o(done_o), .error_o(error_o)
   );

   typedef struct packed {
      logic [63:0] d;
      logic [7:0]  k;
      logic        f;
      logic        l;
      logic [15:0] len;
   } beat_t;

   typedef struct packed {
      logic [63:0] d;
      logic        f;
      logic        l;
   } in_t;

   beat_t exp_q[$];
   in_t   in_q[$];
   int    total = 0;
   int    bad = 0;
   int    done_cnt = 0, err_cnt = 0, exp_done = 0, exp_err = 0;
   int    rx_cnt = 0;
   logic [7:0] rx_keep = 8'h00;
   logic  chk_en = 1'b0;
   logic  rnd_ready = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, req);
      end
   endtask

   // Reference: split the transfer into <=256-byte packets, pad the last to a power of two
   // (min 16 bytes); the user sees the first ceil(bytes/8) wire beats.
   task automatic build(input logic [15:0] len, input int short_t);
      int    nbytes, rem, pb, nbeats, user, nvalid;
      in_t   b;
      beat_t e;
      logic [7:0] kmask;
      nbytes = int'(len) + 1;
      rem    = nbytes;
      in_q.delete();
      while (rem > 0) begin
         if (rem >= 256) pb = 256;
         else begin
            pb = 16;
            while (pb < rem) pb = pb * 2;
         end
         for (int j = 0; j < pb / 8; j++) begin
            b.d = {$urandom, $urandom};
            b.f = (j == 0);
            b.l = (j == pb / 8 - 1);
            in_q.push_back(b);
         end
         rem = rem - ((rem >= 256) ? 256 : rem);
      end
      nbeats = (nbytes + 7) / 8;
      if (short_t > 0) begin
         while (in_q.size() > short_t) void'(in_q.pop_back());
         b = in_q[short_t - 1];
         b.l = 1'b1;
         in_q[short_t - 1] = b;
         user = short_t;
         exp_err++;
      end else begin
         user = nbeats;
      end
      nvalid = (nbytes - 1) % 8 + 1;
      kmask = 8'h00;
      for (int j = 0; j < nvalid; j++) kmask[7 - j] = 1'b1;
      for (int i = 0; i < user; i++) begin
         e.d   = in_q[i].d;
         e.k   = (i == nbeats - 1) ? kmask : 8'hFF;
         e.f   = (i == 0);
         e.l   = (i == user - 1);
         e.len = len;
         exp_q.push_back(e);
      end
      exp_done++;
   endtask

   task automatic send_beat(input logic [63:0] d, input logic f, input logic l, input logic [15:0] len);
      int w = 0;
      input_tvalid   = 1'b1;
      input_tdata    = d;
      input_tfirst   = f;
      input_tlast    = l;
      input_data_len = len;
      while (!input_tready && w < 300) begin
         @(negedge clk);
         w++;
      end
      if (!input_tready) begin
         total++;
         bad++;
         $display("FAIL send_timeout tready=%0b required=1", input_tready);
      end
      @(negedge clk);
      input_tvalid = 1'b0;
   endtask

   task automatic send_stream(input logic [15:0] len, input int from, input logic gaps);
      for (int i = from; i < in_q.size(); i++) begin
         if (gaps && ($urandom_range(0, 3) == 0)) @(negedge clk);
         send_beat(in_q[i].d, in_q[i].f, in_q[i].l, len);
      end
   endtask

   task automatic drain();
      int w = 0;
      while ((exp_q.size() != 0 || data_valid_out) && w < 5000) begin
         @(negedge clk);
         w++;
      end
      repeat (3) @(negedge clk);
      if (w >= 5000) begin
         total++;
         bad++;
         $display("FAIL drain_timeout pending=%0d required=0", exp_q.size());
      end
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_tready"}, input_tready, 0);
      chk({tag, "_valid"}, data_valid_out, 0);
      chk({tag, "_first"}, data_first_out, 0);
      chk({tag, "_last"}, data_last_out, 0);
      chk({tag, "_keep"}, data_keep_out, 0);
      chk({tag, "_data"}, data_out, 0);
      chk({tag, "_len"}, data_len_out, 0);
      chk({tag, "_done"}, done_o, 0);
      chk({tag, "_error"}, error_o, 0);
   endtask

   always @(posedge clk) begin
      #1;
      if (rnd_ready) data_ready_in = ($urandom_range(0, 3) != 0);
   end

   always @(negedge clk) begin
      beat_t e;
      if (chk_en) begin
         if (done_o) done_cnt++;
         if (error_o) err_cnt++;
         if (data_valid_out && data_ready_in) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_beat data=%0h required=none", data_out);
            end else begin
               e = exp_q.pop_front();
               chk("beat_data", data_out, e.d);
               chk("beat_keep", data_keep_out, e.k);
               chk("beat_first", data_first_out, e.f);
               chk("beat_last", data_last_out, e.l);
               chk("beat_len", data_len_out, e.len);
               rx_cnt++;
               rx_keep = data_keep_out;
            end
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int acc, stall, idx, mode, bt;
      logic [15:0] len;
      reset = 1'b0;
      input_tvalid = 1'b0;
      input_tdata = '0;
      input_tfirst = 1'b0;
      input_tlast = 1'b0;
      input_data_len = '0;
      data_ready_in = 1'b1;
      repeat (3) @(negedge clk);
      chk_reset_outputs("rst");
      reset = 1'b1;
      #1;
      chk("rst_release_tready", input_tready, 0);
      chk_en = 1'b1;
      @(negedge clk);

      // 8 bytes: one user beat, one padding beat
      build(16'h0007, 0);
      chk("model_0007_wire_beats", in_q.size(), 2);
      rx_cnt = 0;
      send_stream(16'h0007, 0, 1'b0);
      drain();
      chk("len0007_beats", rx_cnt, 1);
      chk("len0007_keep", rx_keep, 8'hFF);
      chk("len0007_done", done_cnt, exp_done);

      // 259 bytes: 32 + 2 wire beats, 33 user beats
      build(16'h0102, 0);
      chk("model_0102_wire_beats", in_q.size(), 34);
      rx_cnt = 0;
      send_stream(16'h0102, 0, 1'b1);
      drain();
      chk("len0102_beats", rx_cnt, 33);
      chk("len0102_keep", rx_keep, 8'hE0);
      chk("len0102_done", done_cnt, exp_done);

      // exactly one full packet
      build(16'h00FF, 0);
      rx_cnt = 0;
      send_stream(16'h00FF, 0, 1'b0);
      drain();
      chk("len00ff_beats", rx_cnt, 32);
      chk("len00ff_keep", rx_keep, 8'hFF);

      // back-pressure: 16 in FIFO + 1 in output stage
      build(16'h00FF, 0);
      rx_cnt = 0;
      data_ready_in = 1'b0;
      acc = 0;
      stall = 0;
      idx = 0;
      input_tvalid = 1'b1;
      input_tdata = in_q[0].d;
      input_tfirst = in_q[0].f;
      input_tlast = in_q[0].l;
      input_data_len = 16'h00FF;
      while (idx < 32 && stall < 5) begin
         if (input_tready) begin
            @(negedge clk);
            idx++;
            acc++;
            stall = 0;
            if (idx < 32) begin
               input_tdata = in_q[idx].d;
               input_tfirst = in_q[idx].f;
               input_tlast = in_q[idx].l;
            end
         end else begin
            @(negedge clk);
            stall++;
         end
      end
      input_tvalid = 1'b0;
      chk("bp_accepted", acc, 17);
      chk("bp_tready_low", input_tready, 0);
      chk("bp_output_held", data_valid_out, 1);
      data_ready_in = 1'b1;
      send_stream(16'h00FF, idx, 1'b0);
      drain();
      chk("bp_beats", rx_cnt, 32);

      // stray beat in IDLE
      rx_cnt = 0;
      send_beat(64'hDEAD_BEEF_0000_0001, 1'b0, 1'b0, 16'h0000);
      exp_err++;
      drain();
      chk("stray_error", err_cnt, exp_err);
      chk("stray_no_output", rx_cnt, 0);

      // short transfer: 4 beats announced, tlast on beat 2
      build(16'h001F, 2);
      rx_cnt = 0;
      send_stream(16'h001F, 0, 1'b0);
      drain();
      chk("short_beats", rx_cnt, 2);
      chk("short_error", err_cnt, exp_err);
      chk("short_done", done_cnt, exp_done);

      // randomized traffic with random sink stalls
      rnd_ready = 1'b1;
      for (int t = 0; t < 24; t++) begin
         mode = $urandom_range(0, 7);
         if (mode == 0) begin
            len = 16'($urandom_range(15, 255));
            bt = int'(len[15:3]) + 1;
            build(len, $urandom_range(1, bt - 1));
         end else begin
            len = 16'($urandom_range(0, 1023));
            build(len, 0);
         end
         send_stream(len, 0, 1'b1);
         if (mode == 1) begin
            send_beat({$urandom, $urandom}, 1'b0, 1'b1, 16'h0000);
            exp_err++;
         end
      end
      drain();
      chk("rand_done", done_cnt, exp_done);
      chk("rand_error", err_cnt, exp_err);
      rnd_ready = 1'b0;
      data_ready_in = 1'b1;

      // reset mid-packet, then a clean 16-byte transfer
      build(16'h00FF, 0);
      for (int i = 0; i < 5; i++) send_beat(in_q[i].d, in_q[i].f, in_q[i].l, 16'h00FF);
      chk_en = 1'b0;
      reset = 1'b0;
      #1;
      chk_reset_outputs("midrst");
      exp_q.delete();
      repeat (2) @(negedge clk);
      reset = 1'b1;
      #1;
      chk("midrst_release_tready", input_tready, 0);
      done_cnt = 0;
      err_cnt = 0;
      exp_done = 0;
      exp_err = 0;
      chk_en = 1'b1;
      @(negedge clk);
      build(16'h000F, 0);
      rx_cnt = 0;
      send_stream(16'h000F, 0, 1'b0);
      drain();
      chk("post_rst_beats", rx_cnt, 2);
      chk("post_rst_done", done_cnt, 1);
      chk("post_rst_error", err_cnt, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
